fifo_write_ctrl: RTL and testbench

Parametrised write-side controller for the router's dual-clock packet FIFO. It is the successor of the current write logic.
- Uses a PTR_SZ+1 bit wrap-extended pointer, so all 2**PTR_SZ memory slots are usable.
- Publishes a gray-coded write pointer to the read domain.
- Adds a programmable almost-full flag, a write-side occupancy count and a sticky overflow error.
- Optional packet mode: writes become visible to the reader only on commit, and can be discarded on abort.

---
 rtl/fifo_write_ctrl.sv | 117 +++++++++++
 tb/tb_fifo_write_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_ctrl.sv
// rtl/fifo_write_ctrl.sv - write-side controller for the dual-clock packet FIFO
//
// Purpose: tracks the write pointer, publishes a gray-coded pointer to the read
// domain, and reports full / almost-full / occupancy / overflow. In packet mode
// the published pointer advances only on commit, and pending writes can be
// discarded with abort.
//
// Ports:
//   clk, rst       write-domain clock, synchronous active-high reset
//   winc           write request
//   wcommit        publish pending writes (packet mode only)
//   wabort         discard pending writes (packet mode only)
//   rq2_rptr_gray  read pointer (gray), already synchronised into clk
//   afull_thresh   almost-full level, 1..DEPTH
//   write_en       memory write strobe (combinational)
//   waddr          memory write address
//   wptr_gray      published write pointer (gray), registered
//   wfull          full flag, registered
//   wafull         almost-full flag, registered
//   wcount         occupancy seen from the write side, registered
//   woverflow      sticky: a write was attempted while full
module fifo_write_ctrl #(
    parameter int PTR_SZ   = 3,
    parameter int PKT_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              winc,
    input  logic              wcommit,
    input  logic              wabort,
    input  logic [PTR_SZ:0]   rq2_rptr_gray,
    input  logic [PTR_SZ:0]   afull_thresh,
    output logic              write_en,
    output logic [PTR_SZ-1:0] waddr,
    output logic [PTR_SZ:0]   wptr_gray,
    output logic              wfull,
    output logic              wafull,
    output logic [PTR_SZ:0]   wcount,
    output logic              woverflow
);

    localparam logic [PTR_SZ:0] DEPTH = (PTR_SZ+1)'(1) << PTR_SZ;
    localparam logic [PTR_SZ:0] ONE   = (PTR_SZ+1)'(1);

    logic [PTR_SZ:0] wbin_q, wbin_d;
    logic [PTR_SZ:0] cbin_q, cbin_d;
    logic [PTR_SZ:0] wptr_gray_q;
    logic [PTR_SZ:0] wcount_q, count_d;
    logic [PTR_SZ:0] rbin;
    logic            wfull_q, wafull_q, woverflow_q;
    logic            abort, commit;

    function automatic logic [PTR_SZ:0] gray2bin(input logic [PTR_SZ:0] g);
        logic [PTR_SZ:0] b;
        b[PTR_SZ] = g[PTR_SZ];
        for (int i = PTR_SZ - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign abort  = (PKT_MODE != 0) && wabort;
    assign commit = (PKT_MODE != 0) && wcommit;

    // Uses the registered full flag: a slot freed this cycle is not usable
    // until the next edge, keeping the flag pessimistic.
    assign write_en = winc & ~wfull_q & ~abort;
    assign waddr    = wbin_q[PTR_SZ-1:0];
    assign rbin     = gray2bin(rq2_rptr_gray);

    always_comb begin
        wbin_d = wbin_q;
        cbin_d = cbin_q;
        if (abort) begin
            // Abort rewinds to the last committed point and wins over commit.
            wbin_d = cbin_q;
        end else if (write_en) begin
            wbin_d = wbin_q + ONE;
        end
        if (PKT_MODE == 0) begin
            cbin_d = wbin_d;
        end else if (commit && !abort) begin
            cbin_d = wbin_d;
        end
        // Uncommitted writes still occupy space, so count from the working pointer.
        count_d = wbin_d - rbin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q       <= '0;
            cbin_q       <= '0;
            wptr_gray_q  <= '0;
            wcount_q     <= '0;
            wfull_q      <= 1'b0;
            wafull_q     <= 1'b0;
            woverflow_q  <= 1'b0;
        end else begin
            wbin_q      <= wbin_d;
            cbin_q      <= cbin_d;
            wptr_gray_q <= cbin_d ^ (cbin_d >> 1);
            wcount_q    <= count_d;
            wfull_q     <= (count_d == DEPTH);
            wafull_q    <= (count_d >= afull_thresh);
            if (winc && wfull_q) begin
                woverflow_q <= 1'b1;
            end
        end
    end

    assign wptr_gray = wptr_gray_q;
    assign wfull     = wfull_q;
    assign wafull    = wafull_q;
    assign wcount    = wcount_q;
    assign woverflow = woverflow_q;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb/tb_fifo_write_ctrl.sv - self-checking bench for fifo_write_ctrl (both modes)
module tb_fifo_write_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       winc = 1'b0, wcommit = 1'b0, wabort = 1'b0;
    logic [2:0] rq2_rptr_gray = '0;
    logic [2:0] afull_thresh = 3'd3;

    logic       en0, en1, full0, full1, afull0, afull1, ovf0, ovf1;
    logic [1:0] addr0, addr1;
    logic [2:0] gray0, gray1, cnt0, cnt1;

    logic       dut_we, dut_full, dut_afull, dut_ovf;
    logic [1:0] dut_waddr;
    logic [2:0] dut_gray, dut_cnt;

    bit pkt = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0] gray;
        logic [1:0] waddr;
        logic       full;
        logic       afull;
        logic       ovf;
        logic [2:0] cnt;
    } exp_t;

    exp_t sb[$];

    // reference model state: totals of accepted writes, committed writes, reads
    int wr, cm, rd;
    bit m_full, m_ovf;

    fifo_write_ctrl #(.PTR_SZ(2), .PKT_MODE(0)) u0 (
        .clk(clk), .rst(rst), .winc(winc), .wcommit(wcommit), .wabort(wabort),
        .rq2_rptr_gray(rq2_rptr_gray), .afull_thresh(afull_thresh),
        .write_en(en0), .waddr(addr0), .wptr_gray(gray0), .wfull(full0),
        .wafull(afull0), .wcount(cnt0), .woverflow(ovf0)
    );

    fifo_write_ctrl #(.PTR_SZ(2), .PKT_MODE(1)) u1 (
        .clk(clk), .rst(rst), .winc(winc), .wcommit(wcommit), .wabort(wabort),
        .rq2_rptr_gray(rq2_rptr_gray), .afull_thresh(afull_thresh),
        .write_en(en1), .waddr(addr1), .wptr_gray(gray1), .wfull(full1),
        .wafull(afull1), .wcount(cnt1), .woverflow(ovf1)
    );

    always #5 clk = ~clk;

    always_comb begin
        dut_we    = pkt ? en1    : en0;
        dut_waddr = pkt ? addr1  : addr0;
        dut_gray  = pkt ? gray1  : gray0;
        dut_full  = pkt ? full1  : full0;
        dut_afull = pkt ? afull1 : afull0;
        dut_ovf   = pkt ? ovf1   : ovf0;
        dut_cnt   = pkt ? cnt1   : cnt0;
    end

    function automatic logic [2:0] to_gray(input int b);
        logic [2:0] v;
        v = 3'(b % 8);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (pkt=%0d t=%0t)", tag, got, exp, pkt, $time);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        chk("wptr_gray", dut_gray,  e.gray);
        chk("waddr",     dut_waddr, e.waddr);
        chk("wfull",     dut_full,  e.full);
        chk("wafull",    dut_afull, e.afull);
        chk("woverflow", dut_ovf,   e.ovf);
        chk("wcount",    dut_cnt,   e.cnt);
    endtask

    // Called just after a negedge; returns just after the following negedge.
    task automatic do_reset();
        exp_t e;
        rst = 1'b1; winc = 0; wcommit = 0; wabort = 0;
        rq2_rptr_gray = '0; afull_thresh = 3'd3;
        wr = 0; cm = 0; rd = 0; m_full = 0; m_ovf = 0;
        e = '{gray: 3'd0, waddr: 2'd0, full: 1'b0, afull: 1'b0, ovf: 1'b0, cnt: 3'd0};
        sb.push_back(e);
        @(posedge clk); #1;
        compare_out();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic step(input bit w, input bit c, input bit a, input int r, input int th);
        exp_t e;
        bit   ab, we;
        int   cnt;
        winc = w; wcommit = c; wabort = a;
        rd = r;
        rq2_rptr_gray = to_gray(r);
        afull_thresh = 3'(th);
        ab = pkt && a;
        we = w && !m_full && !ab;
        #1;
        chk("write_en", dut_we, we);
        if (ab) wr = cm;
        else if (we) wr++;
        if (!pkt) cm = wr;
        else if (c && !ab) cm = wr;
        if (w && m_full) m_ovf = 1'b1;
        cnt = wr - r;
        m_full = (cnt == 4);
        e.gray  = to_gray(cm);
        e.waddr = 2'(wr % 4);
        e.full  = m_full;
        e.afull = (cnt >= th);
        e.ovf   = m_ovf;
        e.cnt   = 3'(cnt);
        sb.push_back(e);
        @(posedge clk); #1;
        compare_out();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);

        // streaming mode: fill to full, then overflow
        pkt = 0;
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 3);
        chk("t1_gray_full", dut_gray, 3'b110);
        chk("t1_ovf", dut_ovf, 1);
        // reader frees one slot, then one more write refills
        step(0, 0, 0, 1, 3);
        chk("t2_cnt", dut_cnt, 3);
        step(1, 0, 0, 1, 3);
        chk("t2_gray", dut_gray, 3'b111);

        // wrap with reader keeping pace
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 0, i, 3);
        chk("t3_gray_wrap", dut_gray, 3'b000);
        chk("t3_ovf", dut_ovf, 0);

        // random streaming traffic
        for (int i = 0; i < 60; i++) begin
            int r;
            r = rd;
            if (r < cm && ($urandom % 2) == 1) r++;
            step(bit'($urandom % 2), 0, 0, r, int'($urandom_range(1, 4)));
        end

        // packet mode: writes hidden until commit
        pkt = 1;
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 3);
        chk("t4_gray_hidden", dut_gray, 3'b000);
        step(1, 1, 0, 0, 3);
        chk("t4_gray_commit", dut_gray, 3'b110);

        // commit one, write two, abort (with winc), then abort+commit
        do_reset();
        step(1, 1, 0, 0, 3);
        step(1, 0, 0, 0, 3);
        step(1, 0, 0, 0, 3);
        step(1, 0, 1, 0, 3);
        chk("t5_waddr", dut_waddr, 1);
        chk("t5_gray", dut_gray, 3'b001);
        step(1, 0, 0, 0, 3);
        step(1, 1, 1, 0, 3);
        chk("t5_abort_commit", dut_cnt, 1);

        // reset mid-packet while full and overflowed
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 3);
        do_reset();
        step(1, 0, 0, 0, 3);
        chk("t6_waddr_after", dut_waddr, 1);

        // random packet traffic
        for (int i = 0; i < 80; i++) begin
            int r;
            r = rd;
            if (r < cm && ($urandom % 2) == 1) r++;
            step(bit'($urandom % 2), bit'(($urandom % 4) == 0),
                 bit'(($urandom % 6) == 0), r, int'($urandom_range(1, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
